// File: rtl/swu_pkg.sv
// Shared types and size derivations for the sliding-window write side.
package swu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } swu_state_e;

    function automatic int depth_w(input int buffer_depth, input int mmv_in);
        return buffer_depth / mmv_in;
    endfunction

    function automatic int total_w(input int npixels, input int words_per_px, input int mmv_in);
        return (npixels * words_per_px) / mmv_in;
    endfunction

endpackage

// File: rtl/swu_credit_counter.sv
// Free-slot credit counter, saturating at DEPTH_W and 0.
// SWU_WR_OVERFLOW_CHECK_EN enables the release-while-empty overflow flag.
module swu_credit_counter #(
    parameter  int DEPTH_W = 10,
    localparam int CW      = $clog2(DEPTH_W + 1)
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          clr,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          zero,
    output logic          overflow
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH_W);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = FULL_CNT;
        end else if (inc && !dec && count_q != FULL_CNT) begin
            count_d = count_q + 1'b1;
        end else if (dec && !inc && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count_q <= FULL_CNT;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

`ifdef SWU_WR_OVERFLOW_CHECK_EN
    assign overflow = inc & ~dec & (count_q == FULL_CNT);
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: rtl/swu_wr_control.sv
// Write-side controller: paces input beats into the window buffer and primes the reader.
// SWU_WR_OVERFLOW_CHECK_EN adds a sticky credit-overflow flag.
//
// state  | meaning
// IDLE   | waiting for the first beat of a frame
// FILL   | prefilling; reader still held off
// STREAM | reader released, accepting remaining beats
// DRAIN  | frame fully written; waiting for rd_done
module swu_wr_control
    import swu_pkg::*;
#(
    parameter  int NPIXELS      = 1024,
    parameter  int WORDS_PER_PX = 1,
    parameter  int MMV_IN       = 2,
    parameter  int BUFFER_DEPTH = 20,
    parameter  int PREFILL      = 6,
    localparam int DEPTH_W      = depth_w(BUFFER_DEPTH, MMV_IN),
    localparam int TOTAL_W      = total_w(NPIXELS, WORDS_PER_PX, MMV_IN),
    localparam int AW           = (DEPTH_W > 1) ? $clog2(DEPTH_W) : 1,
    localparam int CW           = $clog2(DEPTH_W + 1),
    localparam int BW           = $clog2(TOTAL_W + 1)
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          s_tvalid,
    output logic          s_tready,
    input  logic          rd_release,
    input  logic          rd_done,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          full,
    output logic [CW-1:0] free_slots,
    output logic          err_overflow
);

    swu_state_e    state_q, state_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [BW-1:0] beat_q, beat_d, beat_next;
    logic          full_q, full_d;
    logic          accept;
    logic          frame_clr;
    logic          credit_zero;
    logic          credit_ovf;
    logic [CW-1:0] credit_count;

    // Gated by aresetn so nothing is offered while reset is held.
    assign s_tready  = aresetn && (state_q != DRAIN) && !credit_zero;
    assign accept    = s_tvalid & s_tready;
    assign wr_en     = accept;
    assign beat_next = beat_q + BW'(accept);

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_next;
        wr_addr_d = wr_addr_q;
        full_d    = full_q;
        frame_clr = 1'b0;

        if (accept) begin
            wr_addr_d = (wr_addr_q == AW'(DEPTH_W - 1)) ? '0 : wr_addr_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                // A frame shorter than the prefill skips streaming entirely.
                if (int'(beat_next) >= TOTAL_W) begin
                    state_d = DRAIN;
                    full_d  = 1'b1;
                end else if (int'(beat_next) >= PREFILL) begin
                    state_d = STREAM;
                    full_d  = 1'b1;
                end
            end
            STREAM: begin
                if (int'(beat_next) >= TOTAL_W) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (rd_done) begin
                    state_d   = IDLE;
                    full_d    = 1'b0;
                    wr_addr_d = '0;
                    beat_d    = '0;
                    frame_clr = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            wr_addr_q <= '0;
            beat_q    <= '0;
            full_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            beat_q    <= beat_d;
            full_q    <= full_d;
        end
    end

    swu_credit_counter #(
        .DEPTH_W (DEPTH_W)
    ) u_credit (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .clr      (frame_clr),
        .inc      (rd_release),
        .dec      (accept),
        .count    (credit_count),
        .zero     (credit_zero),
        .overflow (credit_ovf)
    );

    assign wr_addr    = wr_addr_q;
    assign full       = full_q;
    assign free_slots = credit_count;

`ifdef SWU_WR_OVERFLOW_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | credit_ovf;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_overflow = err_q;
`else
    // Counter drives a constant 0 here, so no checking logic remains.
    assign err_overflow = credit_ovf;
`endif

endmodule
